// File: rtl/pool8_sched_if.sv
// rtl/pool8_sched_if.sv - job config, buffer read, lane and result bus of pool8_sched
interface pool8_sched_if #(
    parameter int ADDR_W = 10
);
    logic              cfg_start;
    logic [2:0]        cfg_P;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_len;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [55:0]       rd_data;
    logic [2:0]        pool_P;
    logic [55:0]       pool_idata;
    logic [7:0]        pool_ivld;
    logic [7:0]        pool_ovld;
    logic [63:0]       pool_odata;
    logic [63:0]       out_data;
    logic              out_vld;
    logic              out_rdy;

    modport master (
        input  cfg_start, cfg_P, cfg_base, cfg_len, rd_data, pool_ovld, pool_odata, out_rdy,
        output busy, done, err, rd_en, rd_addr, pool_P, pool_idata, pool_ivld, out_data, out_vld
    );

    modport slave (
        output cfg_start, cfg_P, cfg_base, cfg_len, rd_data, pool_ovld, pool_odata, out_rdy,
        input  busy, done, err, rd_en, rd_addr, pool_P, pool_idata, pool_ivld, out_data, out_vld
    );
endinterface

// File: rtl/pool8_sched.sv
// rtl/pool8_sched.sv - job sequencer for the 8-lane pooling array
// Fetches 8 words per group, feeds lanes one-hot, packs lane bytes into one result word.
module pool8_sched #(
    parameter int ADDR_W = 10,
    parameter int NLANE  = 8
) (
    input  logic           clk_cal,
    input  logic           rst_cal,
    pool8_sched_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   grp_q, grp_d;
    logic [2:0]          kcnt_q, kcnt_d;
    logic [NLANE-1:0]    mask_q, mask_d;
    logic [8*NLANE-1:0]  res_q, res_d;
    logic                err_q, err_d;
    logic [2:0]          p_q, p_d;
    logic                done_q, done_d;
    logic                rvld_q, rvld_d;
    logic [2:0]          rlane_q, rlane_d;
    logic [ADDR_W-1:0]   addr_c;

    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            grp_q   <= '0;
            kcnt_q  <= '0;
            mask_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            p_q     <= '0;
            done_q  <= 1'b0;
            rvld_q  <= 1'b0;
            rlane_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            grp_q   <= grp_d;
            kcnt_q  <= kcnt_d;
            mask_q  <= mask_d;
            res_q   <= res_d;
            err_q   <= err_d;
            p_q     <= p_d;
            done_q  <= done_d;
            rvld_q  <= rvld_d;
            rlane_q <= rlane_d;
        end
    end

    // word address of lane kcnt in group grp, wrapping at the buffer size
    assign addr_c = base_q + {grp_q[ADDR_W-4:0], 3'b000} + ADDR_W'(kcnt_q);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        grp_d   = grp_q;
        kcnt_d  = kcnt_q;
        mask_d  = mask_q;
        res_d   = res_q;
        err_d   = err_q;
        p_d     = p_q;
        done_d  = 1'b0;
        rvld_d  = (state_q == S_FETCH);
        rlane_d = kcnt_q;

        // first valid per lane wins; a repeat within the group only flags err
        if (state_q == S_FETCH || state_q == S_DRAIN) begin
            for (int k = 0; k < NLANE; k++) begin
                if (bus.pool_ovld[k]) begin
                    if (!mask_q[k]) begin
                        res_d[8*k +: 8] = bus.pool_odata[8*k +: 8];
                        mask_d[k]       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    p_d     = bus.cfg_P;
                    base_d  = bus.cfg_base;
                    len_d   = bus.cfg_len;
                    grp_d   = '0;
                    kcnt_d  = '0;
                    mask_d  = '0;
                    err_d   = 1'b0;
                    state_d = (bus.cfg_len == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                kcnt_d = kcnt_q + 3'd1;
                if (kcnt_q == 3'(NLANE - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mask_d == {NLANE{1'b1}}) begin
                    mask_d  = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_rdy) begin
                    if (grp_q + ADDR_W'(1) == len_q) begin
                        state_d = S_FIN;
                    end else begin
                        grp_d   = grp_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rd_en      = (state_q == S_FETCH);
    assign bus.rd_addr    = (state_q == S_FETCH) ? addr_c : '0;
    assign bus.pool_P     = p_q;
    assign bus.pool_idata = rvld_q ? bus.rd_data : '0;
    assign bus.pool_ivld  = rvld_q ? (8'b1 << rlane_q) : 8'b0;
    assign bus.out_data   = res_q;
    assign bus.out_vld    = (state_q == S_OUT);
endmodule

// File: tb/tb_pool8_sched.sv
// tb/tb_pool8_sched.sv - scoreboard bench for pool8_sched with buffer and lane models
module tb_pool8_sched;
    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool8_sched_if #(.ADDR_W(ADDR_W)) ifc ();
    pool8_sched #(.ADDR_W(ADDR_W), .NLANE(8)) dut (.clk_cal(clk), .rst_cal(rst), .bus(ifc));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // feature buffer: low byte of each word is the low byte of its address
    function automatic logic [55:0] mem_word(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 30'h0, a};
    endfunction

    always @(posedge clk) ifc.rd_data <= ifc.rd_en ? mem_word(ifc.rd_addr) : '1;

    // lanes: echo the input word's low byte LAT cycles after its valid
    logic [7:0]  lv [0:3];
    logic [63:0] ld [0:3];
    logic        inj = 1'b0;
    logic [7:0]  inj_byte = 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin lv[s] <= '0; ld[s] <= '0; end
        end else begin
            lv[0] <= ifc.pool_ivld;
            ld[0] <= {8{ifc.pool_idata[7:0]}};
            for (int s = 1; s < 4; s++) begin lv[s] <= lv[s-1]; ld[s] <= ld[s-1]; end
        end
    end
    always_comb begin
        ifc.pool_ovld  = lv[LAT-1] | (inj ? 8'h08 : 8'h00);
        ifc.pool_odata = ld[LAT-1];
        if (inj) ifc.pool_odata[31:24] = inj_byte;
    end

    logic [ADDR_W-1:0] addr_q [$];
    logic [63:0]       exp_q  [$];
    logic [2:0]        exp_p = '0;

    int hs_cnt = 0, rd_cnt = 0, ovld_cnt = 0, done_cnt = 0;
    int last_hs = 0, last_done = 0, first_rd = 0, first_vld = 0;
    logic busy_at_done = 1'b0;
    logic [2:0] ivld_k = '0;
    logic prev_stall = 1'b0, prev_rd = 1'b0, prev_vld = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            ivld_k = '0; prev_stall = 1'b0; prev_rd = 1'b0; prev_vld = 1'b0;
        end else begin
            if (ifc.rd_en) begin
                rd_cnt++;
                n_tests++;
                if (!prev_rd) first_rd = cyc;
                if (addr_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_addr: unexpected read of %h, none required", ifc.rd_addr);
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = addr_q.pop_front();
                    if (ifc.rd_addr !== a) begin
                        n_fail++; $display("FAIL rd_addr: got %h, required %h", ifc.rd_addr, a);
                    end
                end
            end
            if (ifc.pool_ivld !== 8'h00) begin
                n_tests++;
                if (ifc.pool_ivld !== (8'b1 << ivld_k)) begin
                    n_fail++; $display("FAIL pool_ivld: got %b, required %b", ifc.pool_ivld, 8'b1 << ivld_k);
                end
                ivld_k++;
            end
            if (ifc.busy) begin
                n_tests++;
                if (ifc.pool_P !== exp_p) begin
                    n_fail++; $display("FAIL pool_P: got %0d, required %0d", ifc.pool_P, exp_p);
                end
            end
            if (prev_stall) begin
                n_tests++;
                if (ifc.out_vld !== 1'b1 || ifc.out_data !== prev_data || ifc.rd_en !== 1'b0) begin
                    n_fail++; $display("FAIL stall_hold: vld=%b data=%h rd_en=%b, required vld=1 data=%h rd_en=0",
                                       ifc.out_vld, ifc.out_data, ifc.rd_en, prev_data);
                end
            end
            if (ifc.out_vld) begin
                ovld_cnt++;
                if (!prev_vld) first_vld = cyc;
            end
            if (ifc.out_vld && ifc.out_rdy) begin
                hs_cnt++;
                last_hs = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL out_data: unexpected result %h, none required", ifc.out_data);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (ifc.out_data !== e) begin
                        n_fail++; $display("FAIL out_data: got %h, required %h", ifc.out_data, e);
                    end
                end
            end
            if (ifc.done) begin
                done_cnt++; last_done = cyc; busy_at_done = ifc.busy;
            end
            prev_stall = ifc.out_vld && !ifc.out_rdy;
            prev_data  = ifc.out_data;
            prev_rd    = ifc.rd_en;
            prev_vld   = ifc.out_vld;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [2:0] p, input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] a;
        logic [63:0] w;
        exp_p = p;
        for (int g = 0; g < int'(len); g++) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                a = base + ADDR_W'(g * 8 + k);
                addr_q.push_back(a);
                w[8*k +: 8] = a[7:0];
            end
            exp_q.push_back(w);
        end
        ifc.cfg_start = 1'b1; ifc.cfg_P = p; ifc.cfg_base = base; ifc.cfg_len = len;
        tick();
        ifc.cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 400) begin tick(); n++; end
        n_tests++;
        if (done_cnt == d0) begin
            n_fail++; $display("FAIL %s_timeout: no done in %0d cycles, required done", name, n);
        end
    endtask

    task automatic wait_ivld7(input string name);
        int n = 0;
        while (ifc.pool_ivld[7] !== 1'b1 && n < 100) begin tick(); n++; end
        n_tests++;
        if (ifc.pool_ivld[7] !== 1'b1) begin
            n_fail++; $display("FAIL %s_ivld7: got %b, required 1", name, ifc.pool_ivld[7]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if ({ifc.busy, ifc.done, ifc.err, ifc.rd_en, ifc.out_vld} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b, required 00000",
                               {ifc.busy, ifc.done, ifc.err, ifc.rd_en, ifc.out_vld});
        end
        n_tests++;
        if (ifc.pool_ivld !== 8'h00) begin n_fail++; $display("FAIL reset_ivld: got %h, required 00", ifc.pool_ivld); end
        n_tests++;
        if (ifc.rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h, required 0", ifc.rd_addr); end
        n_tests++;
        if (ifc.pool_idata !== '0) begin n_fail++; $display("FAIL reset_idata: got %h, required 0", ifc.pool_idata); end
        n_tests++;
        if (ifc.pool_P !== 3'd0) begin n_fail++; $display("FAIL reset_pool_P: got %0d, required 0", ifc.pool_P); end
        n_tests++;
        if (ifc.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", ifc.out_data); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int h0 = hs_cnt;
        int r0 = rd_cnt;
        start_job(3'd2, 10'h010, 10'd1);
        @(negedge clk);
        n_tests++;
        if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", ifc.busy); end
        wait_done("single");
        n_tests++;
        if (hs_cnt - h0 != 1) begin n_fail++; $display("FAIL single_results: got %0d, required 1", hs_cnt - h0); end
        n_tests++;
        if (rd_cnt - r0 != 8) begin n_fail++; $display("FAIL single_reads: got %0d, required 8", rd_cnt - r0); end
        n_tests++;
        if (first_vld - first_rd != 8 + 1 + LAT) begin
            n_fail++; $display("FAIL single_latency: got %0d, required %0d", first_vld - first_rd, 8 + 1 + LAT);
        end
        n_tests++;
        if (last_done - last_hs != 2 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL single_done: gap %0d busy %b, required gap 2 busy 0", last_done - last_hs, busy_at_done);
        end
        n_tests++;
        if (ifc.pool_P !== 3'd2) begin n_fail++; $display("FAIL single_pool_P: got %0d, required 2", ifc.pool_P); end
    endtask

    task automatic test_stall();
        int h0 = hs_cnt;
        int n = 0;
        start_job(3'd5, 10'h010, 10'd3);
        while (hs_cnt == h0 && n < 100) begin tick(); n++; end
        ifc.out_rdy = 1'b0;
        n = 0;
        while (ifc.out_vld !== 1'b1 && n < 100) begin tick(); n++; end
        n_tests++;
        if (ifc.out_vld !== 1'b1) begin n_fail++; $display("FAIL stall_vld: got %b, required 1", ifc.out_vld); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ifc.cfg_start = 1'b1; ifc.cfg_P = 3'd0; ifc.cfg_base = 10'h200; ifc.cfg_len = 10'd5;
            end else begin
                ifc.cfg_start = 1'b0;
            end
            n_tests++;
            if (ifc.rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_rd_en: got %b, required 0", ifc.rd_en); end
            tick();
        end
        ifc.cfg_start = 1'b0;
        ifc.out_rdy = 1'b1;
        wait_done("stall");
        n_tests++;
        if (hs_cnt - h0 != 3) begin n_fail++; $display("FAIL stall_results: got %0d, required 3", hs_cnt - h0); end
        n_tests++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_fail++; $display("FAIL stall_leftover: got %0d/%0d, required 0/0", exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_len0();
        int r0 = rd_cnt;
        int v0 = ovld_cnt;
        int d0 = done_cnt;
        start_job(3'd1, 10'h100, 10'd0);
        @(negedge clk);
        n_tests++;
        if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
            n_fail++; $display("FAIL len0_c1: busy %b done %b, required busy 1 done 0", ifc.busy, ifc.done);
        end
        @(negedge clk);
        n_tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b1) begin
            n_fail++; $display("FAIL len0_c2: busy %b done %b, required busy 0 done 1", ifc.busy, ifc.done);
        end
        repeat (5) tick();
        n_tests++;
        if (rd_cnt != r0 || ovld_cnt != v0 || done_cnt != d0 + 1) begin
            n_fail++; $display("FAIL len0_quiet: reads %0d vld %0d dones %0d, required 0 0 1",
                               rd_cnt - r0, ovld_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_err();
        start_job(3'd3, 10'h0A7, 10'd1);
        wait_ivld7("err");
        tick();
        inj = 1'b1; inj_byte = 8'hBB;
        tick();
        inj = 1'b0;
        wait_done("err");
        n_tests++;
        if (ifc.err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, required 1", ifc.err); end
        start_job(3'd4, 10'h050, 10'd1);
        @(negedge clk);
        n_tests++;
        if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, required 0", ifc.err); end
        wait_done("err2");
        n_tests++;
        if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL err_clean_job: got %b, required 0", ifc.err); end
    endtask

    task automatic test_reset_mid();
        int d0, v0, h0;
        start_job(3'd6, 10'h040, 10'd2);
        wait_ivld7("rmid");
        rst = 1'b1;
        addr_q.delete();
        exp_q.delete();
        d0 = done_cnt; v0 = ovld_cnt;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ifc.busy !== 1'b0 || ifc.out_vld !== 1'b0 || ifc.done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_idle: busy %b vld %b done %b, required 000", ifc.busy, ifc.out_vld, ifc.done);
        end
        repeat (20) tick();
        n_tests++;
        if (done_cnt != d0 || ovld_cnt != v0) begin
            n_fail++; $display("FAIL rmid_quiet: dones %0d vld %0d, required 0 0", done_cnt - d0, ovld_cnt - v0);
        end
        h0 = hs_cnt;
        start_job(3'd1, 10'h040, 10'd1);
        wait_done("rmid_restart");
        n_tests++;
        if (hs_cnt - h0 != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rmid_restart: results %0d left %0d, required 1 0", hs_cnt - h0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int h0 = hs_cnt;
        start_job(3'd7, 10'h3FC, 10'd1);
        wait_done("wrap");
        n_tests++;
        if (hs_cnt - h0 != 1 || addr_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_done: results %0d left %0d, required 1 0", hs_cnt - h0, addr_q.size());
        end
    endtask

    initial begin
        ifc.cfg_start = 1'b0; ifc.cfg_P = '0; ifc.cfg_base = '0; ifc.cfg_len = '0;
        ifc.out_rdy = 1'b1;
        test_reset();
        test_single();
        test_stall();
        test_len0();
        test_err();
        test_reset_mid();
        test_wrap();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
